// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO: read-mode encodings and the
// rule that sizes the fill-level counter one bit wider than the pointers.
package fifo_pkg;

    typedef enum logic [0:0] {
        RD_MODE_STD  = 1'b0,
        RD_MODE_FWFT = 1'b1
    } rd_mode_e;

    localparam int FWFT_ON = 1;

    // A level must hold 0..2**depth_width inclusive.
    function automatic int level_width(input int depth_width);
        return depth_width + 1;
    endfunction

    function automatic rd_mode_e decode_mode(input int fwft);
        return (fwft == FWFT_ON) ? RD_MODE_FWFT : RD_MODE_STD;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// The array itself is never reset; only the read register is.
module fifo_sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    localparam int WORDS = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [WORDS];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Array write port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; holds its value when not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// level-decoded status flags and sticky overflow/underflow errors.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH_WIDTH      = 11,
    parameter int FWFT             = 0,
    parameter int ALMOST_FULL_NUM  = 1020,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic                                wr_en,
    output logic                                wr_full,
    output logic                                almost_full,
    output logic [DATA_WIDTH-1:0]               rd_data,
    input  logic                                rd_en,
    output logic                                rd_valid,
    output logic                                rd_empty,
    output logic                                almost_empty,
    output logic [level_width(DEPTH_WIDTH)-1:0] water_level,
    output logic                                overflow,
    output logic                                underflow,
    input  logic                                err_clr
);

    localparam int       LW   = level_width(DEPTH_WIDTH);
    localparam int       CAP  = 1 << DEPTH_WIDTH;
    localparam rd_mode_e MODE = decode_mode(FWFT);

    localparam logic [LW-1:0]          CAP_LVL = LW'(CAP);
    localparam logic [LW-1:0]          AF_LVL  = LW'(ALMOST_FULL_NUM);
    localparam logic [LW-1:0]          AE_LVL  = LW'(ALMOST_EMPTY_NUM);
    localparam logic [LW-1:0]          LVL_ONE = LW'(1);
    localparam logic [DEPTH_WIDTH-1:0] PTR_ONE = DEPTH_WIDTH'(1);

    if (!((ALMOST_EMPTY_NUM < ALMOST_FULL_NUM) && (ALMOST_FULL_NUM <= CAP))) begin : g_threshold_check
        $error("sync_fifo_param: need ALMOST_EMPTY_NUM < ALMOST_FULL_NUM <= capacity");
    end

    logic [DEPTH_WIDTH-1:0] r_wr_ptr;
    logic [DEPTH_WIDTH-1:0] r_rd_ptr;
    logic [LW-1:0]          r_level;
    logic                   r_overflow;
    logic                   r_underflow;
    logic                   r_rd_valid;
    logic                   r_bypass;
    logic [DATA_WIDTH-1:0]  r_bypass_data;

    logic                   w_wr_acc;
    logic                   w_rd_acc;
    logic [DEPTH_WIDTH-1:0] w_wr_ptr_nxt;
    logic [DEPTH_WIDTH-1:0] w_rd_ptr_nxt;
    logic [LW-1:0]          w_level_nxt;
    logic                   w_overflow_nxt;
    logic                   w_underflow_nxt;
    logic                   w_ram_rd_en;
    logic [DEPTH_WIDTH-1:0] w_ram_rd_addr;
    logic                   w_bypass_hit;
    logic [DATA_WIDTH-1:0]  w_ram_q;

    assign wr_full      = (r_level == CAP_LVL);
    assign rd_empty     = (r_level == '0);
    assign almost_full  = (r_level >= AF_LVL);
    assign almost_empty = (r_level <= AE_LVL);
    assign water_level  = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc = wr_en && !wr_full;
    assign w_rd_acc = rd_en && !rd_empty;

    // Pointer/level arithmetic, error flag updates and RAM read steering.
    always_comb begin
        w_wr_ptr_nxt    = r_wr_ptr;
        w_rd_ptr_nxt    = r_rd_ptr;
        w_level_nxt     = r_level;
        w_overflow_nxt  = r_overflow;
        w_underflow_nxt = r_underflow;
        w_ram_rd_en     = 1'b0;
        w_ram_rd_addr   = r_rd_ptr;
        w_bypass_hit    = 1'b0;

        if (w_wr_acc) begin
            w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
        end else begin
            w_wr_ptr_nxt = r_wr_ptr;
        end

        if (w_rd_acc) begin
            w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end

        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase

        if (wr_en && wr_full) begin
            w_overflow_nxt = 1'b1;
        end else if (err_clr) begin
            w_overflow_nxt = 1'b0;
        end else begin
            w_overflow_nxt = r_overflow;
        end

        if (rd_en && rd_empty) begin
            w_underflow_nxt = 1'b1;
        end else if (err_clr) begin
            w_underflow_nxt = 1'b0;
        end else begin
            w_underflow_nxt = r_underflow;
        end

        // FWFT keeps the output register tracking the head every cycle; a word
        // written to the slot that becomes the head is forwarded around the RAM.
        if (MODE == RD_MODE_FWFT) begin
            w_ram_rd_en   = 1'b1;
            w_ram_rd_addr = w_rd_ptr_nxt;
            w_bypass_hit  = w_wr_acc && (r_wr_ptr == w_rd_ptr_nxt);
        end else begin
            w_ram_rd_en   = w_rd_acc;
            w_ram_rd_addr = r_rd_ptr;
            w_bypass_hit  = 1'b0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_bypass    <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_level     <= w_level_nxt;
            r_overflow  <= w_overflow_nxt;
            r_underflow <= w_underflow_nxt;
            r_rd_valid  <= w_rd_acc;
            r_bypass    <= w_bypass_hit;
        end
    end

    // Forwarded write word for the FWFT empty-to-head case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bypass_data <= '0;
        end else if (w_bypass_hit) begin
            r_bypass_data <= wr_data;
        end
    end

    fifo_sdp_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DEPTH_WIDTH)
    ) u_ram (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_ram_rd_en),
        .i_rd_addr (w_ram_rd_addr),
        .o_rd_data (w_ram_q)
    );

    assign rd_data  = r_bypass ? r_bypass_data : w_ram_q;
    assign rd_valid = (MODE == RD_MODE_FWFT) ? !rd_empty : r_rd_valid;

endmodule
